// File: rtl/lsu_if.sv
// Execute-stage request/response channel plus data-RAM port of the load/store unit.
// master is the LSU side; slave is the execute stage / RAM side.
interface lsu_if #(
   parameter int ADDR_W = 4
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [1:0]        req_size_i;
   logic              req_unsigned_i;
   logic [31:0]       req_addr_i;
   logic [31:0]       req_wdata_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [31:0]       rsp_rdata_o;
   logic              rsp_err_o;
   logic [ADDR_W-1:0] mem_raddr_o;
   logic [31:0]       mem_rdata_i;
   logic [ADDR_W-1:0] mem_waddr_o;
   logic [31:0]       mem_wdata_o;
   logic              mem_we_o;

   modport master (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      input  rsp_ready_i, mem_rdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      output mem_raddr_o, mem_waddr_o, mem_wdata_o, mem_we_o
   );

   modport slave (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      output rsp_ready_i, mem_rdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      input  mem_raddr_o, mem_waddr_o, mem_wdata_o, mem_we_o
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: IDLE -> EXEC -> RESP, byte/half/word loads with extension and RMW stores.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return err instead of aligning.
module lsu #(
   parameter int ADDR_W = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   lsu_if.master  bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_reg, state_next;
   logic               we_reg;
   logic [1:0]         size_reg;
   logic               uns_reg;
   logic [ADDR_W+1:0]  addr_reg;
   logic [31:0]        wdata_reg;
   logic [31:0]        rdata_reg;
   logic               err_reg;

   logic               req_fire;
   logic               req_bad;
   logic               misalign;
   logic [1:0]         lane;
   logic [31:0]        shifted;
   logic [31:0]        load_data;
   logic [31:0]        lane_wdata;
   logic [3:0]         byte_en;
   logic [31:0]        merged;
   logic               unused_addr_hi;

   assign unused_addr_hi = ^bus.req_addr_i[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = (bus.req_size_i == 2'b01 && bus.req_addr_i[0]) ||
                     (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign req_bad  = (bus.req_size_i == 2'b11) || misalign;
   assign req_fire = bus.req_valid_i && bus.req_ready_o;

   // Low address bits are forced to natural alignment for the access size.
   always_comb begin
      lane = 2'b00;
      case (size_reg)
         2'b00:   lane = addr_reg[1:0];
         2'b01:   lane = {addr_reg[1], 1'b0};
         default: lane = 2'b00;
      endcase
   end

   assign shifted = bus.mem_rdata_i >> {lane, 3'b000};

   always_comb begin
      load_data = bus.mem_rdata_i;
      case (size_reg)
         2'b00:   load_data = {{24{~uns_reg & shifted[7]}}, shifted[7:0]};
         2'b01:   load_data = {{16{~uns_reg & shifted[15]}}, shifted[15:0]};
         default: load_data = bus.mem_rdata_i;
      endcase
   end

   always_comb begin
      byte_en    = 4'b1111;
      lane_wdata = wdata_reg;
      case (size_reg)
         2'b00: begin
            byte_en    = 4'b0001 << lane;
            lane_wdata = {4{wdata_reg[7:0]}};
         end
         2'b01: begin
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata_reg[15:0]}};
         end
         default: begin
            byte_en    = 4'b1111;
            lane_wdata = wdata_reg;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         assign merged[8*gi +: 8] = byte_en[gi] ? lane_wdata[8*gi +: 8]
                                                : bus.mem_rdata_i[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next      = state_reg;
      bus.req_ready_o = 1'b0;
      bus.rsp_valid_o = 1'b0;
      bus.mem_raddr_o = '0;
      bus.mem_waddr_o = '0;
      bus.mem_wdata_o = '0;
      bus.mem_we_o    = 1'b0;
      case (state_reg)
         IDLE: begin
            bus.req_ready_o = rst_n;
            if (bus.req_valid_i && rst_n)
               state_next = req_bad ? RESP : EXEC;
         end
         EXEC: begin
            bus.mem_raddr_o = addr_reg[ADDR_W+1:2];
            bus.mem_waddr_o = addr_reg[ADDR_W+1:2];
            // Gating with rst_n keeps a reset landing in EXEC from corrupting the RAM.
            bus.mem_we_o    = we_reg && rst_n;
            bus.mem_wdata_o = we_reg ? merged : 32'h0;
            state_next      = RESP;
         end
         RESP: begin
            bus.rsp_valid_o = 1'b1;
            if (bus.rsp_ready_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_reg    <= 1'b0;
         size_reg  <= 2'b00;
         uns_reg   <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (req_fire) begin
               we_reg    <= bus.req_we_i;
               size_reg  <= bus.req_size_i;
               uns_reg   <= bus.req_unsigned_i;
               addr_reg  <= bus.req_addr_i[ADDR_W+1:0];
               wdata_reg <= bus.req_wdata_i;
               rdata_reg <= '0;
               err_reg   <= req_bad;
            end
            EXEC: rdata_reg <= we_reg ? 32'h0 : load_data;
            default: ;
         endcase
      end
   end

   assign bus.rsp_rdata_o = rdata_reg;
   assign bus.rsp_err_o   = err_reg;
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized traffic against a
// byte-addressed reference memory model.
module tb_lsu;
   localparam int AW    = 4;
   localparam int NBYTE = 4 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lsu_if #(.ADDR_W(AW)) bus ();

   lsu #(.ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Data RAM: async read, sync write
   logic [31:0] ram [2**AW];
   assign bus.mem_rdata_i = ram[bus.mem_raddr_o];
   always @(posedge clk) if (bus.mem_we_o) ram[bus.mem_waddr_o] <= bus.mem_wdata_o;

   int we_count = 0;
   always @(posedge clk) if (bus.mem_we_o) we_count++;

   // Reference model: flat little-endian byte memory
   logic [7:0] mb [NBYTE];

   int checks = 0;
   int errors = 0;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   function automatic logic [31:0] model_word(input int idx);
      return {mb[4*idx+3], mb[4*idx+2], mb[4*idx+1], mb[4*idx]};
   endfunction

   task automatic preload(input int idx, input logic [31:0] val);
      ram[idx] = val;
      for (int i = 0; i < 4; i++) mb[4*idx+i] = val[8*i +: 8];
   endtask

   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
      int nb, base;
      logic [63:0] v;
      bit mis;
      rdata = 32'h0;
      nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      mis   = (addr % nb) != 0;
      err   = (size == 2'd3) || (TRAP && mis);
      lat   = err ? 1 : 2;
      if (err) return;
      base = ((addr % NBYTE) / nb) * nb;
      if (we) begin
         for (int i = 0; i < nb; i++) mb[base+i] = wdata[8*i +: 8];
      end else begin
         v = 64'h0;
         for (int i = 0; i < nb; i++) v = v + (64'(mb[base+i]) << (8*i));
         if (!uns && v[8*nb-1]) v = v - (64'd1 << (8*nb));
         rdata = v[31:0];
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         output logic [31:0] rdata, output logic err, output int lat);
      int guard;
      @(negedge clk);
      bus.req_valid_i    = 1'b1;
      bus.req_we_i       = we;
      bus.req_size_i     = size;
      bus.req_unsigned_i = uns;
      bus.req_addr_i     = addr;
      bus.req_wdata_i    = wdata;
      bus.rsp_ready_i    = 1'b0;
      guard = 0;
      while (!bus.req_ready_o && guard < 20) begin @(negedge clk); guard++; end
      checks++;
      if (bus.req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL req_accept: req_ready_o=%b required 1", bus.req_ready_o);
      end
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus.rsp_valid_o && lat < 10);
      checks++;
      if (bus.rsp_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL rsp_timeout: rsp_valid_o=%b required 1 within 10 cycles", bus.rsp_valid_o);
      end
      rdata = bus.rsp_rdata_o;
      err   = bus.rsp_err_o;
      repeat (hold) @(negedge clk);
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready_i = 1'b0;
      $display("tx we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
               we, size, uns, addr, wdata, rdata, err, lat);
   endtask

   // Issue a request and check rdata/err/latency against the model.
   task automatic run_check(input string name, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                            input int hold);
      logic [31:0] r, er;
      logic e, ee;
      int l, el;
      model(we, size, uns, addr, wdata, er, ee, el);
      do_req(we, size, uns, addr, wdata, hold, r, e, l);
      checks++;
      if (r !== er || e !== ee || l != el) begin
         errors++;
         $display("FAIL %s: rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=%0d",
                  name, r, e, l, er, ee, el);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (bus.req_ready_o !== 1'b0 || bus.mem_we_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 ||
          bus.rsp_rdata_o !== 32'h0 || bus.rsp_err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ready=%b we=%b valid=%b rdata=%h err=%b required 0 0 0 0 0",
                  bus.req_ready_o, bus.mem_we_o, bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_o);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: req_ready_o=%b required 1", bus.req_ready_o);
      end
   endtask

   task automatic test_word();
      run_check("sw_0x8", 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 0);
      checks++;
      if (ram[2] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL sw_ram2: ram=%h required deadbeef", ram[2]);
      end
      run_check("lw_0x8", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 0);
   endtask

   task automatic test_byte_rmw();
      preload(1, 32'h11223344);
      run_check("sb_0x6", 1'b1, 2'd0, 1'b0, 32'h6, 32'h000000AB, 0);
      checks++;
      if (ram[1] !== 32'h11AB3344) begin
         errors++;
         $display("FAIL sb_ram1: ram=%h required 11ab3344", ram[1]);
      end
      run_check("lb_0x6", 1'b0, 2'd0, 1'b0, 32'h6, 32'h0, 0);
      run_check("lbu_0x6", 1'b0, 2'd0, 1'b1, 32'h6, 32'h0, 1);
   endtask

   task automatic test_half_rmw();
      preload(0, 32'h0);
      run_check("sh_0x2", 1'b1, 2'd1, 1'b0, 32'h2, 32'h00008001, 0);
      checks++;
      if (ram[0] !== 32'h80010000) begin
         errors++;
         $display("FAIL sh_ram0: ram=%h required 80010000", ram[0]);
      end
      run_check("lh_0x2", 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 0);
      run_check("lhu_0x2", 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 2);
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_r, dummy_r, old3;
      logic exp_e, dummy_e;
      int exp_l, dummy_l;
      old3 = ram[3];
      model(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, exp_r, exp_e, exp_l);
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'd2;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h8; bus.rsp_ready_i = 1'b0;
      @(posedge clk); #1;
      // Second request (SW 0xC) is presented while the first response is stalled.
      bus.req_we_i = 1'b1; bus.req_addr_i = 32'hC; bus.req_wdata_i = 32'h55;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== exp_r || bus.req_ready_o !== 1'b0 ||
             ram[3] !== old3) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b rdata=%h ready=%b ram3=%h required 1 %h 0 %h",
                     k, bus.rsp_valid_o, bus.rsp_rdata_o, bus.req_ready_o, ram[3], exp_r, old3);
         end
         @(negedge clk);
      end
      $display("tx we=0 size=2 uns=0 addr=00000008 rdata=%h err=%0d (stalled 5)", bus.rsp_rdata_o,
               bus.rsp_err_o);
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_after: req_ready_o=%b required 1", bus.req_ready_o);
      end
      model(1'b1, 2'd2, 1'b0, 32'hC, 32'h55, dummy_r, dummy_e, dummy_l);
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || ram[3] !== 32'h55) begin
         errors++;
         $display("FAIL bp_second: valid=%b ram3=%h required 1 00000055", bus.rsp_valid_o, ram[3]);
      end
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready_i = 1'b0;
      $display("tx we=1 size=2 uns=0 addr=0000000c wdata=00000055 (queued behind stall)");
   endtask

   task automatic test_misalign();
      int w0;
      logic [31:0] old1;
      run_check("lw_0x5", 1'b0, 2'd2, 1'b0, 32'h5, 32'h0, 0);
      old1 = ram[1];
      w0 = we_count;
      run_check("sw_0x5", 1'b1, 2'd2, 1'b0, 32'h5, 32'hCAFEF00D, 0);
      checks++;
      if ((we_count - w0) != (TRAP ? 0 : 1) || ram[1] !== model_word(1)) begin
         errors++;
         $display("FAIL sw_0x5_write: writes=%0d ram1=%h required writes=%0d ram1=%h (was %h)",
                  we_count - w0, ram[1], TRAP ? 0 : 1, model_word(1), old1);
      end
      run_check("lh_0x7", 1'b0, 2'd1, 1'b0, 32'h7, 32'h0, 0);
      w0 = we_count;
      run_check("rsv_store", 1'b1, 2'd3, 1'b0, 32'h4, 32'h12345678, 0);
      run_check("rsv_load", 1'b0, 2'd3, 1'b1, 32'h8, 32'h0, 0);
      checks++;
      if (we_count != w0) begin
         errors++;
         $display("FAIL rsv_no_write: writes=%0d required 0", we_count - w0);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] old1;
      old1 = ram[1];
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd2;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h4; bus.req_wdata_i = 32'h1;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.mem_we_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_gate: mem_we_o=%b req_ready_o=%b required 0 0",
                  bus.mem_we_o, bus.req_ready_o);
      end
      @(negedge clk);
      checks++;
      if (ram[1] !== old1 || bus.rsp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ram: ram1=%h rsp_valid=%b required %h 0", ram[1], bus.rsp_valid_o, old1);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_idle: req_ready_o=%b rsp_valid=%b required 1 0",
                  bus.req_ready_o, bus.rsp_valid_o);
      end
      $display("tx we=1 size=2 addr=00000004 wdata=00000001 aborted by reset ram1=%h", ram[1]);
   endtask

   task automatic test_random();
      logic we, uns;
      logic [1:0] size;
      logic [31:0] addr, wdata;
      int idx;
      for (int n = 0; n < 60; n++) begin
         we    = 1'($urandom_range(0, 1));
         size  = 2'($urandom_range(0, 3));
         uns   = 1'($urandom_range(0, 1));
         addr  = $urandom;
         wdata = $urandom;
         run_check("random", we, size, uns, addr, wdata, $urandom_range(0, 2));
         if (we) begin
            idx = int'(addr[AW+1:2]);
            checks++;
            if (ram[idx] !== model_word(idx)) begin
               errors++;
               $display("FAIL random_ram: idx=%0d ram=%h required %h", idx, ram[idx], model_word(idx));
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) preload(i, 32'h0);
      bus.req_valid_i    = 1'b0;
      bus.req_we_i       = 1'b0;
      bus.req_size_i     = 2'd0;
      bus.req_unsigned_i = 1'b0;
      bus.req_addr_i     = 32'h0;
      bus.req_wdata_i    = 32'h0;
      bus.rsp_ready_i    = 1'b0;
      test_reset();
      test_word();
      test_byte_rmw();
      test_half_rmw();
      test_backpressure();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
